// File: rtl/core_pkg.sv
// Shared front-end definitions: default address width, reset vector and the
// next-PC source encoding exposed for debug.
package core_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    SRC_HOLD = 3'd0,
    SRC_SEQ  = 3'd1,
    SRC_SET  = 3'd2,
    SRC_RET  = 3'd3,
    SRC_TRAP = 3'd4
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push beyond capacity overwrites the oldest
// entry, and top_data always shows entry[ptr-1].
module pc_ras
  import core_pkg::*;
#(
  parameter  int XLEN      = XLEN_DEF,
  parameter  int RAS_DEPTH = 4,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic [CW-1:0]   cnt
);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx_s;

  // Pointer and occupancy update; clear dominates, and pop on empty is a no-op.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = {PW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && (cnt_q != {CW{1'b0}})) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[ptr_q] <= push_data;
    end
  end

  assign top_idx_s = ptr_q - PW'(1);
  assign top_data  = mem_q[top_idx_s];
  assign cnt       = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: priority mux (trap > set/call > ret > seq > hold)
// feeding the PC register, plus the return-address stack.
module pc_gen
  import core_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              STEP      = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                       i_CLK,
  input  logic                       i_RST_N,
  input  logic                       i_EN,
  input  logic [XLEN-1:0]            i_pc,
  input  logic                       i_pc_set,
  input  logic                       i_call,
  input  logic                       i_ret,
  input  logic                       i_trap,
  input  logic [XLEN-1:0]            i_trap_vec,
  output logic [XLEN-1:0]            o_pc,
  output logic [$clog2(RAS_DEPTH):0] o_ras_cnt,
  output logic                       o_ras_miss
);

  localparam int              CW        = $clog2(RAS_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP_V    = XLEN'(STEP);
  localparam logic [XLEN-1:0] ADDR_MASK = ~(STEP_V - XLEN'(1));

  logic [XLEN-1:0] pc_q, pc_d;
  logic            miss_q, miss_d;
  logic [XLEN-1:0] seq_s, ras_top_s;
  logic [CW-1:0]   ras_cnt_s;
  logic            push_s, pop_s, clear_s;
  pc_src_e         src_s;

  assign seq_s = pc_q + STEP_V;

  // Source selection and stack control, in redirect priority order.
  always_comb begin
    src_s   = SRC_HOLD;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    clear_s = 1'b0;
    miss_d  = 1'b0;
    if (i_trap) begin
      src_s   = SRC_TRAP;
      clear_s = 1'b1;
    end else if (i_pc_set) begin
      src_s  = SRC_SET;
      push_s = i_call & i_EN;
    end else if (i_ret && i_EN) begin
      if (ras_cnt_s != {CW{1'b0}}) begin
        src_s = SRC_RET;
        pop_s = 1'b1;
      end else begin
        src_s  = SRC_SEQ;
        miss_d = 1'b1;
      end
    end else if (i_EN) begin
      src_s = SRC_SEQ;
    end else begin
      src_s = SRC_HOLD;
    end
  end

  // Next-PC mux; every loaded target is aligned down to STEP.
  always_comb begin
    pc_d = pc_q;
    case (src_s)
      SRC_TRAP: pc_d = i_trap_vec & ADDR_MASK;
      SRC_SET:  pc_d = i_pc & ADDR_MASK;
      SRC_RET:  pc_d = ras_top_s & ADDR_MASK;
      SRC_SEQ:  pc_d = seq_s;
      SRC_HOLD: pc_d = pc_q;
      default:  pc_d = pc_q;
    endcase
  end

  // PC and miss-pulse registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      pc_q   <= RESET_VEC;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      miss_q <= miss_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (i_CLK),
    .rst_n     (i_RST_N),
    .push      (push_s),
    .pop       (pop_s),
    .clear     (clear_s),
    .push_data (seq_s),
    .top_data  (ras_top_s),
    .cnt       (ras_cnt_s)
  );

  assign o_pc       = pc_q;
  assign o_ras_cnt  = ras_cnt_s;
  assign o_ras_miss = miss_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic against a
// queue-based reference model of the PC and return stack.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, pc_set, call, ret, trap;
  logic [31:0] pc_in, tv;
  logic [31:0] o_pc;
  logic [2:0]  o_ras_cnt;
  logic        o_ras_miss;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  bit          m_miss;

  localparam logic [31:0] RV   = 32'h0000_0056;
  localparam logic [31:0] MASK = 32'hFFFF_FFFC;

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .STEP(4), .RAS_DEPTH(4)) dut (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_EN       (en),
    .i_pc       (pc_in),
    .i_pc_set   (pc_set),
    .i_call     (call),
    .i_ret      (ret),
    .i_trap     (trap),
    .i_trap_vec (tv),
    .o_pc       (o_pc),
    .o_ras_cnt  (o_ras_cnt),
    .o_ras_miss (o_ras_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit e, input bit s, input logic [31:0] p, input bit c,
                       input bit r, input bit t, input logic [31:0] v);
    en = e; pc_set = s; pc_in = p; call = c; ret = r; trap = t; tv = v;
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_ras.delete();
    m_miss = 1'b0;
  endtask

  // Reference behaviour: a plain queue, newest at the back, oldest dropped.
  task automatic model_step();
    logic [31:0] ret_addr;
    m_miss = 1'b0;
    if (trap) begin
      m_pc = tv & MASK;
      m_ras.delete();
    end else if (pc_set) begin
      if (call && en) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) m_ras.delete(0);
      end
      m_pc = pc_in & MASK;
    end else if (ret && en) begin
      if (m_ras.size() > 0) begin
        ret_addr = m_ras.pop_back();
        m_pc = ret_addr & MASK;
      end else begin
        m_pc = m_pc + 32'd4;
        m_miss = 1'b1;
      end
    end else if (en) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk({tag, ".pc"}, o_pc, m_pc);
    chk({tag, ".cnt"}, 32'(o_ras_cnt), 32'(m_ras.size()));
    chk({tag, ".miss"}, 32'(o_ras_miss), 32'(m_miss));
  endtask

  task automatic rand_drive();
    drive($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 29) == 0, $urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.pc", o_pc, 32'h0000_0056);
    chk("rst.cnt", 32'(o_ras_cnt), 32'd0);
    chk("rst.miss", 32'(o_ras_miss), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.hold", o_pc, 32'h0000_0056);
    end
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
    cycle("seq1"); chk("seq1.abs", o_pc, 32'h0000_005A);
    cycle("seq2"); chk("seq2.abs", o_pc, 32'h0000_005E);

    drive(1, 1, 32'h100, 0, 0, 0, 32'h0);  cycle("go100");
    drive(1, 1, 32'h2003, 0, 0, 0, 32'h0); cycle("set");  chk("set.abs", o_pc, 32'h2000);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0);    cycle("set+1"); chk("set1.abs", o_pc, 32'h2004);
    drive(0, 1, 32'h2003, 0, 0, 0, 32'h0); cycle("setst"); chk("setst.abs", o_pc, 32'h2000);
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0);    cycle("setst+1"); chk("setst1.abs", o_pc, 32'h2000);

    drive(1, 1, 32'h40, 0, 0, 0, 32'h0);  cycle("go40");
    drive(1, 1, 32'h800, 1, 0, 0, 32'h0); cycle("call");
    chk("call.abs", o_pc, 32'h800); chk("call.cnt", 32'(o_ras_cnt), 32'd1);
    drive(1, 0, 32'h0, 0, 1, 0, 32'h0);   cycle("ret");
    chk("ret.abs", o_pc, 32'h44); chk("ret.cnt", 32'(o_ras_cnt), 32'd0);

    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 32'(i) << 12, 1, 0, 0, 32'h0);
      cycle("ovf.call");
    end
    chk("ovf.cnt", 32'(o_ras_cnt), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      drive(1, 0, 32'h0, 0, 1, 0, 32'h0);
      cycle("ovf.ret");
      chk("ovf.ret.abs", o_pc, (32'(i) << 12) + 32'd4);
    end
    cycle("ovf.miss");
    chk("ovf.miss.pc", o_pc, 32'h1008); chk("ovf.miss.abs", 32'(o_ras_miss), 32'd1);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0); cycle("ovf.clr");
    chk("ovf.clr.abs", 32'(o_ras_miss), 32'd0);

    drive(1, 1, 32'h300, 1, 0, 0, 32'h0); cycle("tc1");
    drive(1, 1, 32'h400, 1, 0, 0, 32'h0); cycle("tc2");
    chk("tc.cnt2", 32'(o_ras_cnt), 32'd2);
    drive(1, 1, 32'h999, 0, 1, 1, 32'h1C0); cycle("trap");
    chk("trap.abs", o_pc, 32'h1C0); chk("trap.cnt", 32'(o_ras_cnt), 32'd0);

    drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0); cycle("top");
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0);         cycle("wrap");
    chk("wrap.abs", o_pc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rand_drive();
      cycle("rnd");
    end

    #2 rst_n = 1'b0;
    #1;
    chk("arst.pc", o_pc, 32'h0000_0056);
    chk("arst.cnt", 32'(o_ras_cnt), 32'd0);
    chk("arst.miss", 32'(o_ras_miss), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_drive();
      cycle("rnd2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
